// File: rtl/adc_jesd204_capture_seq.sv
// JESD204 ADC capture sequencer: arms on start, optionally waits for a
// trigger edge, aligns to SOF and forwards a fixed number of beats to DMA.
module adc_jesd204_capture_seq #(
  parameter int NUM_LANES    = 1,
  parameter int LENGTH_WIDTH = 16
) (
  input  logic                      adc_clk,
  input  logic                      adc_rstn,
  input  logic                      cfg_start,
  input  logic                      cfg_abort,
  input  logic                      cfg_trig_mode,
  input  logic [LENGTH_WIDTH-1:0]   cfg_length,
  input  logic                      trig_in,
  input  logic [3:0]                rx_sof,
  input  logic                      rx_valid,
  input  logic [NUM_LANES*32-1:0]   rx_data,
  input  logic                      adc_dovf,
  output logic                      out_valid,
  output logic [NUM_LANES*32-1:0]   out_data,
  output logic                      out_last,
  output logic                      status_busy,
  output logic                      status_done,
  output logic                      status_ovf,
  output logic                      status_err,
  output logic [LENGTH_WIDTH-1:0]   beat_count
);

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    WAIT_SOF,
    CAPTURE,
    DONE
  } state_t;

  state_t                    state;
  state_t                    state_nxt;
  logic [LENGTH_WIDTH-1:0]   len_q;
  logic [LENGTH_WIDTH-1:0]   count_inc;
  logic                      trig_q;
  logic                      trig_edge;
  logic                      start_ok;
  logic                      start_bad;
  logic                      cap;
  logic                      cap_last;
  logic                      unused_sof;

  // Only lane-0 SOF marks frame alignment; the other flags are ignored.
  assign unused_sof = ^rx_sof[3:1];

  assign trig_edge = trig_in & ~trig_q;
  assign count_inc = beat_count + LENGTH_WIDTH'(1);

  assign status_busy = (state == ARMED) ||
                       (state == WAIT_SOF) ||
                       (state == CAPTURE);
  assign status_done = (state == DONE);

  always_comb begin
    state_nxt = state;
    start_ok  = 1'b0;
    start_bad = 1'b0;
    cap       = 1'b0;
    cap_last  = 1'b0;
    if (cfg_abort) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (cfg_start) begin
            if (cfg_length != '0) begin
              start_ok  = 1'b1;
              state_nxt = cfg_trig_mode ? ARMED : WAIT_SOF;
            end else begin
              start_bad = 1'b1;
            end
          end
        end
        ARMED: begin
          if (trig_edge) state_nxt = WAIT_SOF;
        end
        WAIT_SOF: begin
          if (rx_valid && rx_sof[0]) begin
            cap       = 1'b1;
            cap_last  = (count_inc == len_q);
            state_nxt = cap_last ? DONE : CAPTURE;
          end
        end
        CAPTURE: begin
          if (rx_valid) begin
            cap      = 1'b1;
            cap_last = (count_inc == len_q);
            if (cap_last) state_nxt = DONE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge adc_clk) begin
    if (!adc_rstn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge adc_clk) begin
    if (!adc_rstn) begin
      trig_q     <= 1'b0;
      len_q      <= '0;
      beat_count <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      out_data   <= '0;
      status_ovf <= 1'b0;
      status_err <= 1'b0;
    end else begin
      trig_q     <= trig_in;
      out_valid  <= cap;
      out_last   <= cap_last;
      status_err <= start_bad;
      if (cap) out_data <= rx_data;
      if (start_ok) begin
        len_q      <= cfg_length;
        beat_count <= '0;
        status_ovf <= 1'b0;
      end else begin
        if (cap) beat_count <= count_inc;
        // Overflow only matters while beats are being streamed out.
        if (state == CAPTURE && adc_dovf) status_ovf <= 1'b1;
      end
    end
  end

endmodule
